ct_ifu_icache_refill_wr: RTL and testbench



---
 rtl/ct_ifu_icache_pkg.sv | 36 +++
 rtl/ct_ifu_icache_refill_wr_sram_ctrl_reg.sv | 85 ++++++++
 rtl/ct_ifu_icache_refill_wr.sv | 198 +++++++++++++++++++
 tb/tb_ct_ifu_icache_refill_wr.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ct_ifu_icache_pkg.sv
// Shared definitions for the IFU icache refill write sequencer.
// Holds refill FSM encoding, array geometry and line/beat index field positions.
// Pure declarations and one index-building helper; no logic state lives here.
package ct_ifu_icache_pkg;

  // Array geometry
  localparam int BEATS  = 4;    // 128-bit beats per refill line
  localparam int DATA_W = 128;  // beat / array data width
  localparam int IDX_W  = 16;   // icache index width
  localparam int CNT_W  = 2;    // beat counter width, covers 0..BEATS-1

  // Index field layout: the beat number sits just above the 8-byte offset bits
  // and the line address occupies the rest of the index.
  localparam int BEAT_LSB = 3;
  localparam int BEAT_MSB = 4;
  localparam int LINE_LSB = 5;
  localparam int LINE_MSB = 15;
  localparam int LINE_W   = LINE_MSB - LINE_LSB + 1;

  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WRITE = 2'b01,
    ST_DONE  = 2'b10
  } refill_st_e;

  // SRAM index for one beat of a line: {line, beat, 3'b0}
  function automatic logic [IDX_W-1:0] beat_index(
    input logic [LINE_W-1:0] line,
    input logic [CNT_W-1:0]  beat
  );
    beat_index = {line, beat, {BEAT_LSB{1'b0}}};
  endfunction

endpackage

// File: rtl/ct_ifu_icache_refill_wr_sram_ctrl_reg.sv
// Output register stage for the icache data-array controls (both ways).
// Latency: next-cycle values presented at t appear on the SRAM pins at t+1.
// Backpressure: none; index and din only update when their load strobe is set.
//
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_cen_b0/i_clk_en0           way0 chip enable (active low) / clock enable, next cycle
//   i_cen_b1/i_clk_en1           way1 chip enable (active low) / clock enable, next cycle
//   i_wen_b                      shared write enable (active low), next cycle
//   i_idx_ld/i_idx               load strobe and value for the shared index
//   i_din_ld/i_din               load strobe and value for the shared write data
//   o_*                          registered versions driven to the array wrappers
module ct_ifu_icache_refill_wr_sram_ctrl_reg
  import ct_ifu_icache_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_cen_b0,
  input  logic              i_clk_en0,
  input  logic              i_cen_b1,
  input  logic              i_clk_en1,
  input  logic              i_wen_b,
  input  logic              i_idx_ld,
  input  logic [IDX_W-1:0]  i_idx,
  input  logic              i_din_ld,
  input  logic [DATA_W-1:0] i_din,
  output logic              o_cen_b0,
  output logic              o_clk_en0,
  output logic              o_cen_b1,
  output logic              o_clk_en1,
  output logic              o_wen_b,
  output logic [IDX_W-1:0]  o_idx,
  output logic [DATA_W-1:0] o_din
);

  logic              r_cen_b0;
  logic              r_clk_en0;
  logic              r_cen_b1;
  logic              r_clk_en1;
  logic              r_wen_b;
  logic [IDX_W-1:0]  r_idx;
  logic [DATA_W-1:0] r_din;

  // Enables are rewritten every cycle so an idle cycle always parks the arrays.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cen_b0  <= 1'b1;
      r_clk_en0 <= 1'b0;
      r_cen_b1  <= 1'b1;
      r_clk_en1 <= 1'b0;
      r_wen_b   <= 1'b1;
    end else begin
      r_cen_b0  <= i_cen_b0;
      r_clk_en0 <= i_clk_en0;
      r_cen_b1  <= i_cen_b1;
      r_clk_en1 <= i_clk_en1;
      r_wen_b   <= i_wen_b;
    end
  end

  // Index and data hold across idle cycles to avoid needless toggling on the
  // wide array buses.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_idx <= '0;
      r_din <= '0;
    end else begin
      if (i_idx_ld) begin
        r_idx <= i_idx;
      end
      if (i_din_ld) begin
        r_din <= i_din;
      end
    end
  end

  assign o_cen_b0  = r_cen_b0;
  assign o_clk_en0 = r_clk_en0;
  assign o_cen_b1  = r_cen_b1;
  assign o_clk_en1 = r_clk_en1;
  assign o_wen_b   = r_wen_b;
  assign o_idx     = r_idx;
  assign o_din     = r_din;

endmodule

// File: rtl/ct_ifu_icache_refill_wr.sv
// Sequences L2 refill-line writes and fetch reads onto the two icache data arrays.
// Latency: a beat or fetch accepted at t drives the SRAM controls at t+1.
// Backpressure: refill beats always win; fetch is granted only in slots with no beat.
//
// Ports:
//   forever_cpuclk, cpurst          clock, synchronous active-high reset
//   refill_req_*                    line request (index[15:5], way) with vld/rdy
//   refill_data_*                   128-bit beat stream with vld/rdy
//   refill_abort                    drops an in-flight line, no done pulse
//   refill_done / refill_busy       completion pulse / line in progress
//   fetch_req_vld, fetch_index      fetch read request; fetch_grant is combinational
//   ifu_icache_*                    registered SRAM controls for array0/array1
module ct_ifu_icache_refill_wr
  import ct_ifu_icache_pkg::*;
(
  input  logic              forever_cpuclk,
  input  logic              cpurst,
  input  logic              refill_req_vld,
  input  logic [IDX_W-1:0]  refill_req_index,
  input  logic              refill_req_way,
  output logic              refill_req_rdy,
  input  logic              refill_data_vld,
  input  logic [DATA_W-1:0] refill_data,
  output logic              refill_data_rdy,
  input  logic              refill_abort,
  output logic              refill_done,
  output logic              refill_busy,
  input  logic              fetch_req_vld,
  input  logic [IDX_W-1:0]  fetch_index,
  output logic              fetch_grant,
  output logic [IDX_W-1:0]  ifu_icache_index,
  output logic              ifu_icache_data_array0_cen_b,
  output logic              ifu_icache_data_array0_clk_en,
  output logic              ifu_icache_data_array1_cen_b,
  output logic              ifu_icache_data_array1_clk_en,
  output logic              ifu_icache_data_wen_b,
  output logic [DATA_W-1:0] ifu_icache_data_din
);

  refill_st_e        r_state;
  refill_st_e        w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic [LINE_W-1:0] r_line;
  logic              r_way;

  logic              w_req_hs;
  logic              w_beat_hs;

  // Next-cycle SRAM controls
  logic              w_cen_b0;
  logic              w_clk_en0;
  logic              w_cen_b1;
  logic              w_clk_en1;
  logic              w_wen_b;
  logic              w_idx_ld;
  logic [IDX_W-1:0]  w_idx;
  logic              w_din_ld;

  // Offset bits below the line field are not part of the line address.
  logic              w_unused_req_idx_lsb;
  assign w_unused_req_idx_lsb = ^refill_req_index[LINE_LSB-1:0];

  assign w_req_hs  = refill_req_vld  & refill_req_rdy;
  assign w_beat_hs = refill_data_vld & refill_data_rdy;

  // A beat owns the arrays next cycle; DONE is kept free so the final write
  // and the completion pulse never share a slot with a read.
  assign fetch_grant = fetch_req_vld & ~w_beat_hs & (r_state != ST_DONE);

  //--------------------------------------------------------------------------
  // Refill FSM
  //--------------------------------------------------------------------------
  always_ff @(posedge forever_cpuclk) begin
    if (cpurst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Line address and way are only meaningful while a line is in flight, so
  // they are captured on the request handshake without needing a reset.
  always_ff @(posedge forever_cpuclk) begin
    if (w_req_hs) begin
      r_line <= refill_req_index[LINE_MSB:LINE_LSB];
      r_way  <= refill_req_way;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    refill_req_rdy  = 1'b0;
    refill_data_rdy = 1'b0;
    refill_busy     = 1'b0;
    refill_done     = 1'b0;

    case (r_state)
      ST_IDLE: begin
        refill_req_rdy = 1'b1;
        if (refill_req_vld) begin
          w_state_nxt = ST_WRITE;
          w_cnt_nxt   = '0;
        end
      end

      ST_WRITE: begin
        refill_data_rdy = 1'b1;
        refill_busy     = 1'b1;
        if (refill_data_vld) begin
          if (r_cnt == LAST_BEAT) begin
            w_state_nxt = ST_DONE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
        // Abort overrides the beat's state effect; the beat itself is still
        // written because the SRAM path below only looks at the handshake.
        if (refill_abort) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      end

      ST_DONE: begin
        refill_done = ~refill_abort;
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end

      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  //--------------------------------------------------------------------------
  // Array port arbitration: refill beat > fetch read > idle
  //--------------------------------------------------------------------------
  always_comb begin
    w_cen_b0  = 1'b1;
    w_clk_en0 = 1'b0;
    w_cen_b1  = 1'b1;
    w_clk_en1 = 1'b0;
    w_wen_b   = 1'b1;
    w_idx_ld  = 1'b0;
    w_idx     = fetch_index;
    w_din_ld  = 1'b0;

    if (w_beat_hs) begin
      w_wen_b  = 1'b0;
      w_idx_ld = 1'b1;
      w_idx    = beat_index(r_line, r_cnt);
      w_din_ld = 1'b1;
      if (r_way) begin
        w_cen_b1  = 1'b0;
        w_clk_en1 = 1'b1;
      end else begin
        w_cen_b0  = 1'b0;
        w_clk_en0 = 1'b1;
      end
    end else if (fetch_grant) begin
      // Reads hit both ways so the tag compare can pick the hitting way later.
      w_cen_b0  = 1'b0;
      w_clk_en0 = 1'b1;
      w_cen_b1  = 1'b0;
      w_clk_en1 = 1'b1;
      w_idx_ld  = 1'b1;
    end
  end

  ct_ifu_icache_refill_wr_sram_ctrl_reg u_sram_ctrl_reg (
    .i_clk     (forever_cpuclk),
    .i_rst     (cpurst),
    .i_cen_b0  (w_cen_b0),
    .i_clk_en0 (w_clk_en0),
    .i_cen_b1  (w_cen_b1),
    .i_clk_en1 (w_clk_en1),
    .i_wen_b   (w_wen_b),
    .i_idx_ld  (w_idx_ld),
    .i_idx     (w_idx),
    .i_din_ld  (w_din_ld),
    .i_din     (refill_data),
    .o_cen_b0  (ifu_icache_data_array0_cen_b),
    .o_clk_en0 (ifu_icache_data_array0_clk_en),
    .o_cen_b1  (ifu_icache_data_array1_cen_b),
    .o_clk_en1 (ifu_icache_data_array1_clk_en),
    .o_wen_b   (ifu_icache_data_wen_b),
    .o_idx     (ifu_icache_index),
    .o_din     (ifu_icache_data_din)
  );

endmodule

// File: tb/tb_ct_ifu_icache_refill_wr.sv
module tb_ct_ifu_icache_refill_wr;

  localparam int K_IDLE = 0;  // arrays parked
  localparam int K_RD   = 1;  // read both ways
  localparam int K_W0   = 2;  // write way0
  localparam int K_W1   = 3;  // write way1

  logic         clk;
  logic         rst;
  logic         req_vld;
  logic [15:0]  req_index;
  logic         req_way;
  logic         req_rdy;
  logic         data_vld;
  logic [127:0] data;
  logic         data_rdy;
  logic         abort;
  logic         done;
  logic         busy;
  logic         fetch_vld;
  logic [15:0]  fetch_index;
  logic         grant;
  logic [15:0]  sram_index;
  logic         cen_b0, clk_en0, cen_b1, clk_en1, wen_b;
  logic [127:0] din;

  int checks = 0;
  int errors = 0;

  ct_ifu_icache_refill_wr dut (
    .forever_cpuclk                (clk),
    .cpurst                        (rst),
    .refill_req_vld                (req_vld),
    .refill_req_index              (req_index),
    .refill_req_way                (req_way),
    .refill_req_rdy                (req_rdy),
    .refill_data_vld               (data_vld),
    .refill_data                   (data),
    .refill_data_rdy               (data_rdy),
    .refill_abort                  (abort),
    .refill_done                   (done),
    .refill_busy                   (busy),
    .fetch_req_vld                 (fetch_vld),
    .fetch_index                   (fetch_index),
    .fetch_grant                   (grant),
    .ifu_icache_index              (sram_index),
    .ifu_icache_data_array0_cen_b  (cen_b0),
    .ifu_icache_data_array0_clk_en (clk_en0),
    .ifu_icache_data_array1_cen_b  (cen_b1),
    .ifu_icache_data_array1_clk_en (clk_en1),
    .ifu_icache_data_wen_b         (wen_b),
    .ifu_icache_data_din           (din)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         rqv;
    logic [15:0]  rqidx;
    logic         rqway;
    logic         dv;
    logic [127:0] d;
    logic         ab;
    logic         fv;
    logic [15:0]  fidx;
    // expected during the cycle (combinational)
    logic         rr;
    logic         dr;
    logic         g;
    logic         dn;
    logic         bz;
    // expected after the edge (registered)
    int           kind;
    logic [15:0]  idx;
    logic [127:0] din;
  } vec_t;

  vec_t         vecs[$];
  logic [127:0] dd[16];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // State-level expectation: which comb outputs each FSM phase shows
  // st: 0 IDLE, 1 WRITE, 2 DONE
  function automatic vec_t mk(input int st, input logic r, input logic rqv, input logic [15:0] rqidx,
                              input logic rqway, input logic dv, input logic [127:0] d, input logic ab,
                              input logic fv, input logic [15:0] fidx, input logic g,
                              input int kind, input logic [15:0] idx, input logic [127:0] dn_din);
    vec_t v;
    v.rst = r; v.rqv = rqv; v.rqidx = rqidx; v.rqway = rqway; v.dv = dv; v.d = d;
    v.ab = ab; v.fv = fv; v.fidx = fidx; v.g = g;
    v.rr = (st == 0);
    v.dr = (st == 1);
    v.bz = (st == 1);
    v.dn = (st == 2);
    v.kind = kind; v.idx = idx; v.din = dn_din;
    return v;
  endfunction

  task automatic chk_ctrl(input string nm, input int kind);
    logic [4:0] exp;
    case (kind)
      K_RD:    exp = 5'b0_1_0_1_1;
      K_W0:    exp = 5'b0_1_1_0_0;
      K_W1:    exp = 5'b1_0_0_1_0;
      default: exp = 5'b1_0_1_0_1;
    endcase
    chk({nm, "_ctrl"}, {123'd0, cen_b0, clk_en0, cen_b1, clk_en1, wen_b}, {123'd0, exp});
  endtask

  logic [7:0] pat;
  int sent, wr, done_seen, done_cnt;
  logic hs;

  initial begin
    for (int i = 0; i < 16; i++) dd[i] = {8{16'hA000 + 16'(i * 16'h0111)}};

    //        st r rqv rqidx     way dv d      ab fv fidx      g  kind    idx       din
    vecs.push_back(mk(0, 1, 0, 16'h0000, 0, 0, 0,     0, 0, 16'h0000, 0, K_IDLE, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0,     0, 1, 16'h1238, 1, K_RD,   16'h1238, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0,     0, 0, 16'h0000, 0, K_IDLE, 16'h1238, 0));
    vecs.push_back(mk(0, 0, 1, 16'h0A40, 1, 0, 0,     0, 1, 16'h0100, 1, K_RD,   16'h0100, 0));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, dd[0], 0, 0, 16'h0000, 0, K_W1,   16'h0A40, dd[0]));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, dd[1], 0, 0, 16'h0000, 0, K_W1,   16'h0A48, dd[1]));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, dd[2], 0, 0, 16'h0000, 0, K_W1,   16'h0A50, dd[2]));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, dd[3], 0, 1, 16'h2222, 0, K_W1,   16'h0A58, dd[3]));
    vecs.push_back(mk(2, 0, 0, 16'h0000, 0, 0, 0,     0, 1, 16'h2222, 0, K_IDLE, 16'h0A58, dd[3]));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0,     0, 1, 16'h2222, 1, K_RD,   16'h2222, dd[3]));
    // way0 line with a bubble; fetch requested throughout
    vecs.push_back(mk(0, 0, 1, 16'h3C67, 0, 0, 0,     0, 1, 16'h4440, 1, K_RD,   16'h4440, dd[3]));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, dd[4], 0, 1, 16'h4440, 0, K_W0,   16'h3C60, dd[4]));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, dd[5], 0, 1, 16'h4440, 0, K_W0,   16'h3C68, dd[5]));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 0, 0,     0, 1, 16'h4440, 1, K_RD,   16'h4440, dd[5]));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, dd[6], 0, 1, 16'h4440, 0, K_W0,   16'h3C70, dd[6]));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, dd[7], 0, 1, 16'h4440, 0, K_W0,   16'h3C78, dd[7]));
    vecs.push_back(mk(2, 0, 0, 16'h0000, 0, 0, 0,     0, 1, 16'h4440, 0, K_IDLE, 16'h3C78, dd[7]));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0,     0, 1, 16'h4440, 1, K_RD,   16'h4440, dd[7]));
    // abort together with beat 1
    vecs.push_back(mk(0, 0, 1, 16'h0800, 1, 0, 0,     0, 0, 16'h0000, 0, K_IDLE, 16'h4440, dd[7]));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, dd[8], 0, 0, 16'h0000, 0, K_W1,   16'h0800, dd[8]));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, dd[9], 1, 0, 16'h0000, 0, K_W1,   16'h0808, dd[9]));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0,     1, 0, 16'h0000, 0, K_IDLE, 16'h0808, dd[9]));
    vecs.push_back(mk(0, 0, 1, 16'h1000, 0, 0, 0,     0, 0, 16'h0000, 0, K_IDLE, 16'h0808, dd[9]));
    vecs.push_back(mk(1, 0, 0, 16'h0000, 0, 1, dd[10],0, 0, 16'h0000, 0, K_W0,   16'h1000, dd[10]));
    // reset lands on the second beat
    vecs.push_back(mk(1, 1, 0, 16'h0000, 0, 1, dd[11],0, 0, 16'h0000, 0, K_IDLE, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0,     0, 0, 16'h0000, 0, K_IDLE, 16'h0000, 0));
    vecs.push_back(mk(0, 0, 0, 16'h0000, 0, 0, 0,     0, 1, 16'hFFF8, 1, K_RD,   16'hFFF8, 0));

    rst = 1'b1; req_vld = 0; req_index = 0; req_way = 0; data_vld = 0; data = 0;
    abort = 0; fetch_vld = 0; fetch_index = 0;
    repeat (2) @(posedge clk);
    #1;

    for (int i = 0; i < vecs.size(); i++) begin
      string nm;
      nm = $sformatf("r%0d", i);
      rst = vecs[i].rst; req_vld = vecs[i].rqv; req_index = vecs[i].rqidx; req_way = vecs[i].rqway;
      data_vld = vecs[i].dv; data = vecs[i].d; abort = vecs[i].ab;
      fetch_vld = vecs[i].fv; fetch_index = vecs[i].fidx;
      @(negedge clk);
      chk({nm, "_grant"},    {127'd0, grant},    {127'd0, vecs[i].g});
      chk({nm, "_req_rdy"},  {127'd0, req_rdy},  {127'd0, vecs[i].rr});
      chk({nm, "_data_rdy"}, {127'd0, data_rdy}, {127'd0, vecs[i].dr});
      chk({nm, "_done"},     {127'd0, done},     {127'd0, vecs[i].dn});
      chk({nm, "_busy"},     {127'd0, busy},     {127'd0, vecs[i].bz});
      @(posedge clk);
      #1;
      chk_ctrl(nm, vecs[i].kind);
      chk({nm, "_index"}, {112'd0, sram_index}, {112'd0, vecs[i].idx});
      chk({nm, "_din"},   din,                  vecs[i].din);
    end
    rst = 0; req_vld = 0; data_vld = 0; abort = 0; fetch_vld = 0;

    // Irregular beat stream into way1: every write lands on array1 at the
    // next beat index, and the line completes with a single done pulse.
    req_vld = 1; req_index = 16'h5F00; req_way = 1;
    @(posedge clk);
    #1;
    req_vld = 0;
    pat = 8'b0101_1001;  // bit c = beat offered in cycle c
    sent = 0; wr = 0; done_seen = 0; done_cnt = 0;
    for (int c = 0; c < 40 && done_seen == 0; c++) begin
      data_vld = (sent < 4) && ((c < 8) ? pat[c] : 1'b1);
      data = dd[12 + (sent & 3)];
      @(negedge clk);
      if (done) begin done_seen = 1; done_cnt++; end
      hs = data_vld & data_rdy;
      @(posedge clk);
      #1;
      if (!wen_b) begin
        chk($sformatf("seq_w%0d_ctrl", wr), {123'd0, cen_b0, clk_en0, cen_b1, clk_en1, wen_b}, {123'd0, 5'b1_0_0_1_0});
        chk($sformatf("seq_w%0d_index", wr), {112'd0, sram_index}, {112'd0, 16'h5F00 + 16'(wr * 8)});
        chk($sformatf("seq_w%0d_din", wr), din, dd[12 + (wr & 3)]);
        wr++;
      end
      if (hs) sent++;
    end
    data_vld = 0;
    chk("seq_done_seen", {96'd0, 32'(done_seen)}, {96'd0, 32'd1});
    chk("seq_writes", {96'd0, 32'(wr)}, {96'd0, 32'd4});
    @(negedge clk);
    if (done) done_cnt++;
    chk("seq_done_once", {96'd0, 32'(done_cnt)}, {96'd0, 32'd1});
    chk("seq_req_rdy_after", {127'd0, req_rdy}, {127'd0, 1'b1});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
